// File: rtl/msg_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-ST sink between NUM_SRC sources.
// A grant is held from the first beat until the granted source's tlast beat is accepted.
module msg_stream_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DATA_BYTES  = 8,
  parameter int unsigned TKEEP_WIDTH = 8,
  localparam int unsigned SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arb_en,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  output logic [NUM_SRC-1:0]                s_tready,
  input  logic [NUM_SRC-1:0]                s_tlast,
  input  logic [NUM_SRC-1:0]                s_tuser,
  input  logic [NUM_SRC*8*DATA_BYTES-1:0]   s_tdata,
  input  logic [NUM_SRC*TKEEP_WIDTH-1:0]    s_tkeep,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic                              m_tuser,
  output logic [8*DATA_BYTES-1:0]           m_tdata,
  output logic [TKEEP_WIDTH-1:0]            m_tkeep,
  output logic [SRC_W-1:0]                  m_src_id,
  output logic                              busy
);

  localparam int unsigned DW = 8 * DATA_BYTES;

  typedef enum logic {StIdle, StLock} state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [SRC_W-1:0] cand;
  logic [SRC_W-1:0] req_idx;
  logic             req_found;
  logic             xfer;

  // Search starts one past the previous owner so every requester is served once per round.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = SRC_W'((32'(last_grant_q) + i) % NUM_SRC);
      if (!req_found && s_tvalid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  assign xfer = (state_q == StLock) && m_tvalid && m_tready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (arb_en && req_found) begin
          grant_d = req_idx;
          state_d = StLock;
        end
      end
      StLock: begin
        // No regrant on the tlast edge: one idle bubble separates packets.
        if (xfer && m_tlast) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Pure combinational pass-through of the owning source while locked.
  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    s_tready = '0;
    if (state_q == StLock) begin
      m_tvalid          = s_tvalid[grant_q];
      m_tlast           = s_tlast[grant_q];
      m_tuser           = s_tuser[grant_q];
      m_tdata           = s_tdata[grant_q*DW +: DW];
      m_tkeep           = s_tkeep[grant_q*TKEEP_WIDTH +: TKEEP_WIDTH];
      s_tready[grant_q] = m_tready;
    end
  end

  assign m_src_id = grant_q;
  assign busy     = (state_q == StLock);

endmodule
